// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants and divisor helpers for the tick_gen
// clock-enable generator (tick_gen, tick_chan, tick_gen_if).
package tick_gen_pkg;

   // Default counter / divisor width; wide enough for a 100 MHz clock.
   localparam int CNT_W_DEF = 27;

   // Smallest divisor a channel can run at (tick every other cycle).
   localparam int MIN_DIV = 2;

   // Width used by the helper functions; callers cast to their own CNT_W.
   localparam int DIV_FN_W = 64;

   // Raise any divisor below MIN_DIV up to MIN_DIV.
   function automatic logic [DIV_FN_W-1:0] clamp_div(input logic [DIV_FN_W-1:0] v);
      logic [DIV_FN_W-1:0] min_v;
      min_v = DIV_FN_W'(MIN_DIV);
      return (v < min_v) ? min_v : v;
   endfunction

   // Power-up divisor of channel k: clk_hz / 2^k, never below MIN_DIV.
   function automatic logic [DIV_FN_W-1:0] default_div(input logic [DIV_FN_W-1:0] clk_hz,
                                                       input int unsigned       k);
      return clamp_div(clk_hz >> k);
   endfunction

endpackage

// File: rtl/tick_gen_if.sv
// tick_gen_if: control and status bundle of the tick_gen block.
// Optional macro: TICK_GEN_PAUSE_EN adds the pause signal.
//
// Handshake: div_wr is a single-cycle strobe with no ready. Every strobe
// with an in-range div_sel is accepted on the clock edge where div_wr=1;
// div_busy[k] then reports that channel k holds a divisor not yet applied.
// A later strobe to the same channel replaces the pending divisor.
interface tick_gen_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 27
);
   localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              div_wr;
   logic [SEL_W-1:0]  div_sel;
   logic [CNT_W-1:0]  div_val;
   logic              sync_clr;
`ifdef TICK_GEN_PAUSE_EN
   logic              pause;
`endif
   logic [NUM_CH-1:0] tick_o;
   logic [NUM_CH-1:0] level_o;
   logic [NUM_CH-1:0] div_busy;

   modport master (
      output div_wr, div_sel, div_val, sync_clr,
`ifdef TICK_GEN_PAUSE_EN
      output pause,
`endif
      input  tick_o, level_o, div_busy
   );

   modport slave (
      input  div_wr, div_sel, div_val, sync_clr,
`ifdef TICK_GEN_PAUSE_EN
      input  pause,
`endif
      output tick_o, level_o, div_busy
   );

endinterface

// File: rtl/tick_gen_chan.sv
// tick_chan: one clock-enable channel. Counts 0..D-1, emits a one-cycle
// tick at the terminal count, toggles a 50 % level output on each tick, and
// swaps in a pending divisor only at a terminal count or on sync_clr so the
// output never produces a short period.
module tick_chan
   import tick_gen_pkg::*;
#(
   parameter int               CNT_W   = CNT_W_DEF,
   parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(MIN_DIV)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [CNT_W-1:0] wr_val,
   input  logic             sync_clr,
   input  logic             pause,
   output logic             tick_o,
   output logic             level_o,
   output logic             busy_o
);

   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [CNT_W-1:0] div_q,      div_d;
   logic [CNT_W-1:0] pend_div_q, pend_div_d;
   logic             pend_q,     pend_d;
   logic             tick_q,     tick_d;
   logic             level_q,    level_d;

   logic [CNT_W-1:0] wr_clamped;
   logic             terminal;

   assign wr_clamped = CNT_W'(clamp_div(DIV_FN_W'(wr_val)));
   assign terminal   = (cnt_q == (div_q - CNT_W'(1)));

   // Next-state: sync_clr realigns, pause freezes, otherwise count and
   // apply any pending divisor at the terminal count.
   always_comb begin
      cnt_d      = cnt_q;
      div_d      = div_q;
      pend_div_d = pend_div_q;
      pend_d     = pend_q;
      tick_d     = 1'b0;
      level_d    = level_q;

      if (sync_clr) begin
         cnt_d   = '0;
         level_d = 1'b0;
         pend_d  = 1'b0;
         // A write in the same cycle wins over an older pending value.
         if (wr_en) begin
            div_d = wr_clamped;
         end else if (pend_q) begin
            div_d = pend_div_q;
         end
      end else begin
         if (!pause) begin
            if (terminal) begin
               cnt_d   = '0;
               tick_d  = 1'b1;
               level_d = ~level_q;
               if (pend_q) begin
                  div_d  = pend_div_q;
                  pend_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         // Queued after the apply above, so a write landing on the
         // terminal count stays pending for the following period.
         if (wr_en) begin
            pend_div_d = wr_clamped;
            pend_d     = 1'b1;
         end
      end
   end

   // State register; reset restores the default divisor and drops writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         div_q      <= DEF_DIV;
         pend_div_q <= DEF_DIV;
         pend_q     <= 1'b0;
         tick_q     <= 1'b0;
         level_q    <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         pend_div_q <= pend_div_d;
         pend_q     <= pend_d;
         tick_q     <= tick_d;
         level_q    <= level_d;
      end
   end

   assign tick_o  = tick_q;
   assign level_o = level_q;
   assign busy_o  = pend_q;

endmodule

// File: rtl/tick_gen.sv
// tick_gen: multi-channel programmable clock-enable generator.
// Optional macro: TICK_GEN_PAUSE_EN enables the pause input (freeze).
// Decodes div_sel into per-channel write enables and fans sync_clr/pause
// out to NUM_CH tick_chan instances; all outputs come from channel flops.
// CNT_W must be at least $clog2(CLK_HZ+1) so channel 0's default fits.
module tick_gen
   import tick_gen_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int NUM_CH = 4,
   parameter int CNT_W  = CNT_W_DEF
) (
   input logic       clk,
   input logic       rst_n,
   tick_gen_if.slave bus
);

   localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              pause_all;
   logic [NUM_CH-1:0] wr_en;
   logic [NUM_CH-1:0] tick_v;
   logic [NUM_CH-1:0] level_v;
   logic [NUM_CH-1:0] busy_v;

`ifdef TICK_GEN_PAUSE_EN
   assign pause_all = bus.pause;
`else
   assign pause_all = 1'b0;
`endif

   // Write decode: an index with no matching channel selects nothing.
   always_comb begin
      wr_en = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (bus.div_wr && (bus.div_sel == SEL_W'(k))) begin
            wr_en[k] = 1'b1;
         end
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
      tick_chan #(
         .CNT_W   (CNT_W),
         .DEF_DIV (CNT_W'(default_div(DIV_FN_W'(CLK_HZ), k)))
      ) u_chan (
         .clk      (clk),
         .rst_n    (rst_n),
         .wr_en    (wr_en[k]),
         .wr_val   (bus.div_val),
         .sync_clr (bus.sync_clr),
         .pause    (pause_all),
         .tick_o   (tick_v[k]),
         .level_o  (level_v[k]),
         .busy_o   (busy_v[k])
      );
   end

   assign bus.tick_o   = tick_v;
   assign bus.level_o  = level_v;
   assign bus.div_busy = busy_v;

endmodule
